alu_cmd_sequencer: RTL and testbench

// Initiator-side sequencer for the n-bit combinational ALU.
// - Accepts operation commands over a valid/ready handshake and drives the ALU operands and control.
// - Captures the ALU result and Z/N/V/C flags into registers.
// - Returns them over a second valid/ready handshake.
// - Keeps an accumulator, so chained ops can use the last result as operand A.

---
 rtl/alu_cmd_sequencer_pkg.sv | 28 ++
 rtl/alu_cmd_sequencer_if.sv | 31 +++
 rtl/alu.sv | 47 ++++
 rtl/alu_cmd_sequencer.sv | 119 +++++++++++
 tb/tb_alu_cmd_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types for the ALU command sequencer and its companion ALU.
// Holds the opcode encoding, the flag bit positions and the FSM states.
package alu_cmd_sequencer_pkg;

    typedef enum logic [3:0] {
        OpAdd = 4'b0000,
        OpSub = 4'b0001,
        OpAnd = 4'b0010,
        OpOr  = 4'b0011,
        OpXor = 4'b0100,
        OpSll = 4'b0101,
        OpSlr = 4'b0110,
        OpSar = 4'b0111
    } alu_op_t;

    localparam int unsigned FlagZ = 3;
    localparam int unsigned FlagN = 2;
    localparam int unsigned FlagV = 1;
    localparam int unsigned FlagC = 0;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StCapture,
        StResp
    } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command/response bus between a requester (master) and the sequencer (slave).
// Also carries the accumulator controls and status.
interface alu_cmd_sequencer_if #(
    parameter int unsigned N     = 3,
    parameter int unsigned CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [N-1:0]     cmd_a;
    logic [N-1:0]     cmd_b;
    logic             cmd_use_acc;
    logic             acc_clear;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [N-1:0]     rsp_result;
    logic [3:0]       rsp_flags;
    logic [N-1:0]     acc;
    logic [CNT_W-1:0] op_count;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, acc_clear, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_flags, acc, op_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, acc_clear, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_flags, acc, op_count
    );

endinterface

// File: rtl/alu.sv
// n-bit combinational ALU: add/sub, bitwise logic and shifts with Z/N/V/C flags.
// V and C are only meaningful for add/sub; other ops report them as 0.
module alu
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int unsigned n = 3
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [3:0]   control,
    output logic [n-1:0] result,
    output logic         flag_z,
    output logic         flag_n,
    output logic         flag_v,
    output logic         flag_c
);

    logic [n-1:0] b_eff;
    logic [n:0]   sum;

    // SUB is ADD with b inverted and a carry-in of one
    assign b_eff = control[0] ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {{n{1'b0}}, control[0]};

    always_comb begin
        result = '0;
        flag_v = 1'b0;
        flag_c = 1'b0;
        case (control)
            OpAdd, OpSub: begin
                result = sum[n-1:0];
                flag_c = sum[n];
                flag_v = (a[n-1] == b_eff[n-1]) && (sum[n-1] != a[n-1]);
            end
            OpAnd: result = a & b;
            OpOr:  result = a | b;
            OpXor: result = a ^ b;
            OpSll: result = a << b;
            OpSlr: result = a >> b;
            OpSar: result = $signed(a) >>> b;
            default: result = '0;
        endcase
        flag_z = (result == '0);
        flag_n = result[n-1];
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator-side sequencer: takes commands, drives a combinational ALU, captures
// result and flags, and returns them over a response handshake; keeps an accumulator.
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int unsigned N     = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_cmd_sequencer_if.slave bus,
    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    output logic [3:0]     alu_control,
    input  logic [N-1:0]   alu_result,
    input  logic           alu_z,
    input  logic           alu_n,
    input  logic           alu_v,
    input  logic           alu_c
);

    seq_state_t       state_q, state_d;
    logic [N-1:0]     alu_a_q, alu_a_d;
    logic [N-1:0]     alu_b_q, alu_b_d;
    logic [3:0]       alu_control_q, alu_control_d;
    logic [N-1:0]     rsp_result_q, rsp_result_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic             cmd_ready;
    logic             accept;

    assign cmd_ready = rst_n & ((state_q == StIdle) | ((state_q == StResp) & bus.rsp_ready));
    assign accept    = bus.cmd_valid & cmd_ready;

    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_control_d = alu_control_q;
        rsp_result_d  = rsp_result_q;
        rsp_flags_d   = rsp_flags_q;
        acc_d         = acc_q;
        op_count_d    = op_count_q;

        if (bus.acc_clear) begin
            acc_d = '0;
        end

        // Operand A reads the registered acc, so a same-cycle clear does not affect it
        if (accept) begin
            alu_a_d       = bus.cmd_use_acc ? acc_q : bus.cmd_a;
            alu_b_d       = bus.cmd_b;
            alu_control_d = bus.cmd_op;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StCapture;
            end
            StCapture: begin
                rsp_result_d       = alu_result;
                acc_d              = alu_result;
                rsp_flags_d[FlagZ] = alu_z;
                rsp_flags_d[FlagN] = alu_n;
                rsp_flags_d[FlagV] = alu_v;
                rsp_flags_d[FlagC] = alu_c;
                state_d            = StResp;
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    if (op_count_q != {CNT_W{1'b1}}) begin
                        op_count_d = op_count_q + 1'b1;
                    end
                    state_d = accept ? StIssue : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_control_q <= '0;
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
            acc_q         <= '0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_control_q <= alu_control_d;
            rsp_result_q  <= rsp_result_d;
            rsp_flags_q   <= rsp_flags_d;
            acc_q         <= acc_d;
            op_count_q    <= op_count_d;
        end
    end

    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign alu_control    = alu_control_q;
    assign bus.cmd_ready  = cmd_ready;
    assign bus.rsp_valid  = (state_q == StResp);
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.acc        = acc_q;
    assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer wired to the real ALU (N=3, CNT_W=2): a vector table
// for single operations plus hand sequences for backpressure, reset and acc_clear.
module tb_alu_cmd_sequencer;
    import alu_cmd_sequencer_pkg::*;

    localparam int unsigned N     = 3;
    localparam int unsigned CNT_W = 2;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] alu_a, alu_b, alu_result;
    logic [3:0]   alu_control;
    logic         alu_z, alu_n, alu_v, alu_c;

    int total_checks;
    int passed_checks;

    alu_cmd_sequencer_if #(.N(N), .CNT_W(CNT_W)) bus ();

    alu_cmd_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_z       (alu_z),
        .alu_n       (alu_n),
        .alu_v       (alu_v),
        .alu_c       (alu_c)
    );

    alu #(.n(N)) u_alu (
        .a       (alu_a),
        .b       (alu_b),
        .control (alu_control),
        .result  (alu_result),
        .flag_z  (alu_z),
        .flag_n  (alu_n),
        .flag_v  (alu_v),
        .flag_c  (alu_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         use_acc;
        logic [N-1:0] res;
        logic [3:0]   flags;   // {Z,N,V,C}
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        total_checks++;
        if (act == exp) begin
            passed_checks++;
        end else begin
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command and returns one cycle after the accepting edge (ISSUE)
    task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic use_acc);
        int guard;
        bus.cmd_op      = op;
        bus.cmd_a       = a;
        bus.cmd_b       = b;
        bus.cmd_use_acc = use_acc;
        bus.cmd_valid   = 1'b1;
        guard = 0;
        while (!bus.cmd_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("cmd_ready_wait", int'(guard < 20), 1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Cycles from accept until rsp_valid; called in the cycle after accept
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 12) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int exp_cnt;
        int seen;

        total_checks  = 0;
        passed_checks = 0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = '0;
        bus.cmd_a       = '0;
        bus.cmd_b       = '0;
        bus.cmd_use_acc = 1'b0;
        bus.acc_clear   = 1'b0;
        bus.rsp_ready   = 1'b1;
        rst_n           = 1'b0;

        vecs[0]  = '{OpAdd, 3'd3, 3'd5, 1'b0, 3'b000, 4'b1001};
        vecs[1]  = '{OpSub, 3'd2, 3'd3, 1'b0, 3'b111, 4'b0100};
        vecs[2]  = '{OpAdd, 3'd3, 3'd1, 1'b0, 3'b100, 4'b0110};
        vecs[3]  = '{OpAdd, 3'd7, 3'd1, 1'b1, 3'b101, 4'b0100};
        vecs[4]  = '{OpAnd, 3'd6, 3'd3, 1'b0, 3'b010, 4'b0000};
        vecs[5]  = '{OpXor, 3'd5, 3'd3, 1'b0, 3'b110, 4'b0100};
        vecs[6]  = '{OpSll, 3'd3, 3'd1, 1'b0, 3'b110, 4'b0100};
        vecs[7]  = '{OpSar, 3'd4, 3'd1, 1'b0, 3'b110, 4'b0100};
        vecs[8]  = '{OpSlr, 3'd4, 3'd1, 1'b0, 3'b010, 4'b0000};
        vecs[9]  = '{OpOr,  3'd0, 3'd0, 1'b0, 3'b000, 4'b1000};
        vecs[10] = '{OpSub, 3'd5, 3'd1, 1'b1, 3'b111, 4'b0100};

        #2;
        check("rst_cmd_ready", int'(bus.cmd_ready), 0);
        check("rst_rsp_valid", int'(bus.rsp_valid), 0);
        check("rst_acc", int'(bus.acc), 0);
        check("rst_op_count", int'(bus.op_count), 0);
        check("rst_alu_control", int'(alu_control), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_cmd_ready", int'(bus.cmd_ready), 1);

        // Table: one op at a time, response accepted immediately
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_acc);
            wait_rsp(lat);
            check($sformatf("latency[%0d]", i), lat, 3);
            check($sformatf("result[%0d]", i), int'(bus.rsp_result), int'(vecs[i].res));
            check($sformatf("flags[%0d]", i), int'(bus.rsp_flags), int'(vecs[i].flags));
            check($sformatf("acc[%0d]", i), int'(bus.acc), int'(vecs[i].res));
            tick();
            exp_cnt = (i + 1 > 3) ? 3 : i + 1;
            check($sformatf("op_count[%0d]", i), int'(bus.op_count), exp_cnt);
            check($sformatf("rsp_drop[%0d]", i), int'(bus.rsp_valid), 0);
        end

        // Backpressure, then accept a new command in the handshake cycle
        bus.rsp_ready = 1'b0;
        issue(OpAdd, 3'd1, 3'd2, 1'b0);
        wait_rsp(lat);
        check("bp_latency", lat, 3);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp_valid[%0d]", k), int'(bus.rsp_valid), 1);
            check($sformatf("bp_result[%0d]", k), int'(bus.rsp_result), 3);
            check($sformatf("bp_cmd_ready[%0d]", k), int'(bus.cmd_ready), 0);
        end
        bus.cmd_op      = OpSub;
        bus.cmd_a       = 3'd0;
        bus.cmd_b       = 3'd1;
        bus.cmd_use_acc = 1'b1;
        bus.cmd_valid   = 1'b1;
        bus.rsp_ready   = 1'b1;
        #1;
        check("bp_cmd_ready_on_ready", int'(bus.cmd_ready), 1);
        tick();
        bus.cmd_valid = 1'b0;
        check("bp_rsp_cleared", int'(bus.rsp_valid), 0);
        check("bp_alu_a_from_acc", int'(alu_a), 3);
        wait_rsp(lat);
        check("b2b_latency", lat, 3);
        check("b2b_result", int'(bus.rsp_result), 2);
        check("b2b_flags", int'(bus.rsp_flags), 4'b0001);
        tick();

        // Illegal opcode passes through; reset during ISSUE discards it
        issue(4'hA, 3'd5, 3'd6, 1'b0);
        check("illegal_op_passthru", int'(alu_control), 4'hA);
        check("issue_alu_a", int'(alu_a), 5);
        check("issue_alu_b", int'(alu_b), 6);
        rst_n = 1'b0;
        #1;
        check("midrst_alu_a", int'(alu_a), 0);
        check("midrst_alu_b", int'(alu_b), 0);
        check("midrst_alu_control", int'(alu_control), 0);
        check("midrst_acc", int'(bus.acc), 0);
        check("midrst_op_count", int'(bus.op_count), 0);
        check("midrst_rsp_result", int'(bus.rsp_result), 0);
        check("midrst_cmd_ready", int'(bus.cmd_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.rsp_valid) seen++;
        end
        check("midrst_no_rsp", seen, 0);

        // acc_clear in IDLE
        issue(OpAdd, 3'd2, 3'd2, 1'b0);
        wait_rsp(lat);
        check("pre_clear_acc", int'(bus.acc), 4);
        tick();
        check("post_rst_op_count", int'(bus.op_count), 1);
        bus.acc_clear = 1'b1;
        tick();
        bus.acc_clear = 1'b0;
        check("idle_clear_acc", int'(bus.acc), 0);

        // acc_clear held through CAPTURE: capture wins
        bus.acc_clear = 1'b1;
        issue(OpAdd, 3'd1, 3'd2, 1'b0);
        wait_rsp(lat);
        check("capture_beats_clear", int'(bus.acc), 3);
        bus.acc_clear = 1'b0;
        tick();

        // use_acc with a same-cycle clear sees the pre-clear value
        bus.acc_clear = 1'b1;
        issue(OpAdd, 3'd0, 3'd1, 1'b1);
        bus.acc_clear = 1'b0;
        check("preclear_alu_a", int'(alu_a), 3);
        check("clear_on_accept", int'(bus.acc), 0);
        wait_rsp(lat);
        check("preclear_result", int'(bus.rsp_result), 4);
        tick();

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
